// File: rtl/sd_pkg.sv
// sd_pkg: shared SD SPI-mode command constants, state encoding and CRC7 byte step
package sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_FRAME,
        ST_POLL,
        ST_TRAIL,
        ST_POST,
        ST_DONE
    } state_t;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;
    localparam logic [5:0] CMD58  = 6'd58;

    localparam int R1_IDLE        = 0;
    localparam int R1_ILLEGAL_CMD = 2;

    localparam logic [7:0] NO_OP      = 8'hFF;
    localparam logic [1:0] START_BITS = 2'b01;

    function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] d);
        logic [6:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: registered CRC7 (x^7+x^3+1), one byte folded in per enabled cycle
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [6:0] crc
);

    logic [6:0] crc_q;

    // clear wins over update so a new command always starts from zero
    always_ff @(posedge clk) begin
        if (rst || clr) crc_q <= 7'd0;
        else if (en)    crc_q <= crc7_byte(crc_q, data);
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: frames one SD SPI command, polls R1, collects trailer, drives cs
module sd_cmd_sequencer
    import sd_pkg::*;
#(
    parameter int NCR_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        resp_len,
    input  logic        keep_cs,
    output logic        resp_valid,
    output logic [7:0]  resp_r1,
    output logic [31:0] resp_data,
    output logic        resp_timeout,
    output logic        cs,
    output logic        spi_start,
    output logic [7:0]  spi_tx_byte,
    input  logic [7:0]  spi_rx_byte,
    input  logic        spi_done
);

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  r1_q, r1_d;
    logic [31:0] data_q, data_d;
    logic        to_q, to_d;
    logic        cs_q, cs_d;
    logic [5:0]  idx_q;
    logic [31:0] arg_q;
    logic        len_q;
    logic        keep_q;
    logic [6:0]  crc;
    logic [7:0]  frame_byte;
    logic        accept;
    logic        done;

    assign cmd_ready    = state_q == ST_IDLE;
    assign accept       = cmd_valid && cmd_ready;
    assign done         = busy_q && spi_done;
    assign frame_byte   = cnt_q == 8'd0 ? {START_BITS, idx_q} :
                          cnt_q == 8'd1 ? arg_q[31:24] :
                          cnt_q == 8'd2 ? arg_q[23:16] :
                          cnt_q == 8'd3 ? arg_q[15:8]  :
                          cnt_q == 8'd4 ? arg_q[7:0]   : {crc, 1'b1};
    assign spi_tx_byte  = state_q == ST_FRAME ? frame_byte : NO_OP;
    assign resp_r1      = r1_q;
    assign resp_data    = data_q;
    assign resp_timeout = to_q;
    assign cs           = cs_q;

    sd_crc7 u_crc (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (spi_start && state_q == ST_FRAME && cnt_q < 8'd5),
        .data (frame_byte),
        .crc  (crc)
    );

    // state and response registers; command fields are captured on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= 8'd0;
            r1_q    <= NO_OP;
            data_q  <= 32'd0;
            to_q    <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            r1_q    <= r1_d;
            data_q  <= data_d;
            to_q    <= to_d;
            cs_q    <= cs_d;
        end
        if (accept) begin
            idx_q  <= cmd_index;
            arg_q  <= cmd_arg;
            len_q  <= resp_len;
            keep_q <= keep_cs;
        end
    end

    // byte issue/wait handshake and transaction sequencing
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        r1_d       = r1_q;
        data_d     = data_q;
        to_d       = to_q;
        cs_d       = cs_q;
        resp_valid = 1'b0;
        spi_start  = !busy_q && (state_q inside {ST_PRE, ST_FRAME, ST_POLL, ST_TRAIL} ||
                                 (state_q == ST_POST && !keep_q));
        if (spi_start) busy_d = 1'b1;
        if (done)      busy_d = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = ST_PRE;
                cs_d    = 1'b0;
                to_d    = 1'b0;
                data_d  = 32'd0;
                cnt_d   = 8'd0;
            end
            ST_PRE: if (done) state_d = ST_FRAME;
            ST_FRAME: if (done) begin
                state_d = cnt_q == 8'd5 ? ST_POLL : ST_FRAME;
                cnt_d   = cnt_q == 8'd5 ? 8'd0 : cnt_q + 8'd1;
            end
            ST_POLL: if (done) begin
                if (!spi_rx_byte[7]) begin
                    r1_d    = spi_rx_byte;
                    state_d = len_q && !spi_rx_byte[R1_ILLEGAL_CMD] ? ST_TRAIL : ST_POST;
                    cnt_d   = 8'd0;
                end else if (cnt_q == 8'(NCR_MAX - 1)) begin
                    r1_d    = NO_OP;
                    to_d    = 1'b1;
                    state_d = ST_POST;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_TRAIL: if (done) begin
                data_d  = {data_q[23:0], spi_rx_byte};
                state_d = cnt_q == 8'd3 ? ST_POST : ST_TRAIL;
                cnt_d   = cnt_q + 8'd1;
            end
            ST_POST: if (keep_q || done) state_d = ST_DONE;
            ST_DONE: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_POST && !keep_q) cs_d = 1'b1;
    end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb_sd_cmd_sequencer: directed scoreboard bench with a byte-engine model
module tb_sd_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [5:0]  cmd_index = 6'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic        resp_len = 1'b0;
    logic        keep_cs = 1'b0;
    logic        resp_valid;
    logic [7:0]  resp_r1;
    logic [31:0] resp_data;
    logic        resp_timeout;
    logic        cs;
    logic        spi_start;
    logic [7:0]  spi_tx_byte;
    logic [7:0]  spi_rx_byte;
    logic        spi_done;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int nstart = 0;
    int rv_cnt = 0;
    logic [7:0]  cap_r1;
    logic [31:0] cap_data;
    logic        cap_to;

    logic [7:0] expq[$];
    logic       expcs[$];
    logic [7:0] rxq[$];

    sd_cmd_sequencer #(.NCR_MAX(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .resp_len     (resp_len),
        .keep_cs      (keep_cs),
        .resp_valid   (resp_valid),
        .resp_r1      (resp_r1),
        .resp_data    (resp_data),
        .resp_timeout (resp_timeout),
        .cs           (cs),
        .spi_start    (spi_start),
        .spi_tx_byte  (spi_tx_byte),
        .spi_rx_byte  (spi_rx_byte),
        .spi_done     (spi_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_crc7(input logic [39:0] bits);
        logic [6:0] c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            if (c[6] ^ bits[i]) c = {c[5:0], 1'b0} ^ 7'h09;
            else                c = {c[5:0], 1'b0};
        end
        return c;
    endfunction

    task automatic push_tx(input logic [7:0] b, input logic c);
        expq.push_back(b);
        expcs.push_back(c);
    endtask

    task automatic push_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] b5);
        push_tx(8'hFF, 1'b0);
        push_tx({2'b01, idx}, 1'b0);
        for (int i = 3; i >= 0; i--) push_tx(arg[8*i +: 8], 1'b0);
        push_tx(b5, 1'b0);
        for (int i = 0; i < 7; i++) rxq.push_back(8'hFF);
    endtask

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic len, input logic keep);
        int i;
        for (i = 0; i < 50 && !cmd_ready; i++) begin
            @(posedge clk);
            #1;
        end
        check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_index = idx;
        cmd_arg   = arg;
        resp_len  = len;
        keep_cs   = keep;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(input int rv0, input string tag);
        int i;
        for (i = 0; i < 600 && rv_cnt == rv0; i++) @(posedge clk);
        check({tag, "_resp_seen"}, {31'd0, rv_cnt != rv0}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_pulses"}, 32'(rv_cnt - rv0), 32'd1);
        check({tag, "_tx_left"}, 32'(expq.size()), 32'd0);
    endtask

    // byte-engine model: checks each issued byte against the scoreboard, answers 3 cycles later
    initial begin
        logic [7:0] e;
        logic       c;
        spi_done    = 1'b0;
        spi_rx_byte = 8'hFF;
        forever begin
            @(posedge clk);
            #1;
            spi_done = 1'b0;
            if (spi_start) begin
                nstart++;
                check("start_expected", {31'd0, expq.size() != 0}, 32'd1);
                e = expq.size() != 0 ? expq.pop_front() : 8'h00;
                c = expcs.size() != 0 ? expcs.pop_front() : 1'b1;
                check("tx_byte", {24'd0, spi_tx_byte}, {24'd0, e});
                check("tx_cs", {31'd0, cs}, {31'd0, c});
                repeat (2) @(posedge clk);
                #1;
                spi_done    = 1'b1;
                spi_rx_byte = rxq.size() != 0 ? rxq.pop_front() : 8'hFF;
            end
        end
    end

    always @(negedge clk) begin
        if (resp_valid) begin
            rv_cnt   <= rv_cnt + 1;
            cap_r1   <= resp_r1;
            cap_data <= resp_data;
            cap_to   <= resp_timeout;
        end
    end

    initial begin
        int rv0;
        int n0;
        int i;
        logic [7:0] b5;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_cs", {31'd0, cs}, 32'd1);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_start", {31'd0, spi_start}, 32'd0);
        check("rst_tx", {24'd0, spi_tx_byte}, 32'hFF);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_r1", {24'd0, resp_r1}, 32'hFF);
        check("rst_data", resp_data, 32'd0);
        check("rst_to", {31'd0, resp_timeout}, 32'd0);

        // CMD0: R1 on second poll
        push_frame(6'd0, 32'd0, 8'h95);
        push_tx(8'hFF, 1'b0);
        push_tx(8'hFF, 1'b0);
        push_tx(8'hFF, 1'b1);
        rxq.push_back(8'hFF);
        rxq.push_back(8'h01);
        rv0 = rv_cnt;
        issue(6'd0, 32'd0, 1'b0, 1'b0);
        wait_resp(rv0, "cmd0");
        check("cmd0_r1", {24'd0, cap_r1}, 32'h01);
        check("cmd0_to", {31'd0, cap_to}, 32'd0);
        check("cmd0_cs", {31'd0, cs}, 32'd1);

        // CMD8 with R7 trailer
        push_frame(6'd8, 32'h000001AA, 8'h87);
        push_tx(8'hFF, 1'b0);
        for (int k = 0; k < 4; k++) push_tx(8'hFF, 1'b0);
        push_tx(8'hFF, 1'b1);
        rxq.push_back(8'h01);
        rxq.push_back(8'h00);
        rxq.push_back(8'h00);
        rxq.push_back(8'h01);
        rxq.push_back(8'hAA);
        rv0 = rv_cnt;
        issue(6'd8, 32'h000001AA, 1'b1, 1'b0);
        wait_resp(rv0, "cmd8");
        check("cmd8_r1", {24'd0, cap_r1}, 32'h01);
        check("cmd8_data", cap_data, 32'h000001AA);
        check("cmd8_to", {31'd0, cap_to}, 32'd0);

        // CMD8 answered as illegal: trailer skipped
        push_frame(6'd8, 32'h000001AA, 8'h87);
        push_tx(8'hFF, 1'b0);
        push_tx(8'hFF, 1'b1);
        rxq.push_back(8'h05);
        rv0 = rv_cnt;
        issue(6'd8, 32'h000001AA, 1'b1, 1'b0);
        wait_resp(rv0, "illegal");
        check("illegal_r1", {24'd0, cap_r1}, 32'h05);
        check("illegal_data", cap_data, 32'd0);

        // no R1 at all: timeout after exactly 8 polls
        b5 = {ref_crc7({2'b01, 6'd55, 32'd0}), 1'b1};
        push_frame(6'd55, 32'd0, b5);
        for (int k = 0; k < 8; k++) push_tx(8'hFF, 1'b0);
        push_tx(8'hFF, 1'b1);
        rv0 = rv_cnt;
        issue(6'd55, 32'd0, 1'b0, 1'b0);
        wait_resp(rv0, "timeout");
        check("timeout_flag", {31'd0, cap_to}, 32'd1);
        check("timeout_r1", {24'd0, cap_r1}, 32'hFF);
        check("timeout_data", cap_data, 32'd0);
        check("timeout_cs", {31'd0, cs}, 32'd1);

        // CMD17 keeping cs low, with a stray request mid-frame
        b5 = {ref_crc7({2'b01, 6'd17, 32'h00000200}), 1'b1};
        push_frame(6'd17, 32'h00000200, b5);
        push_tx(8'hFF, 1'b0);
        rxq.push_back(8'h00);
        rv0 = rv_cnt;
        issue(6'd17, 32'h00000200, 1'b0, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        cmd_index = 6'd58;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_resp(rv0, "keep");
        check("keep_r1", {24'd0, cap_r1}, 32'h00);
        check("keep_cs_low", {31'd0, cs}, 32'd0);
        check("keep_ready", {31'd0, cmd_ready}, 32'd1);

        // reset while FRAME byte 3 is outstanding
        push_frame(6'd0, 32'd0, 8'h95);
        n0  = nstart;
        rv0 = rv_cnt;
        issue(6'd0, 32'd0, 1'b0, 1'b0);
        for (i = 0; i < 200 && nstart < n0 + 5; i++) begin
            @(posedge clk);
            #2;
        end
        check("rst_mid_reached", 32'(nstart - n0), 32'd5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_cs", {31'd0, cs}, 32'd1);
        check("rst_mid_ready", {31'd0, cmd_ready}, 32'd1);
        expq.delete();
        expcs.delete();
        rxq.delete();
        n0 = nstart;
        repeat (30) @(posedge clk);
        #1;
        check("rst_mid_no_start", 32'(nstart - n0), 32'd0);
        check("rst_mid_no_valid", 32'(rv_cnt - rv0), 32'd0);
        check("rst_mid_cs_hold", {31'd0, cs}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
Sequences one complete SD SPI-mode command transaction over the shared byte transceiver (spi_controller-style byte engine). It frames the command as 6 bytes with a computed CRC7, polls for the R1 response, optionally collects a 4-byte R3/R7 trailer, and manages chip select. It sits between the card init/data FSMs and the byte engine, so no upstream FSM builds frames or counts poll bytes.

Parameters:
NCR_MAX, 8, maximum 0xFF poll bytes sent while waiting for R1 (bit7==0) before timeout; legal range 1..255.

Ports:
clk  in  1  master clock; all logic on posedge.
rst  in  1  synchronous active-high reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  high only in IDLE; accept on cmd_valid && cmd_ready.
cmd_index  in  6  SD command index.
cmd_arg  in  32  command argument.
resp_len  in  1  0 = R1 only; 1 = R1 + 4 trailing bytes.
keep_cs  in  1  1 = leave cs low after the response for a data phase.
resp_valid  out  1  one-cycle pulse: transaction complete.
resp_r1  out  8  R1 byte.
resp_data  out  32  trailer, first received byte in [31:24].
resp_timeout  out  1  valid with resp_valid; R1 not seen within NCR_MAX.
cs  out  1  card chip select, active low.
spi_start  out  1  one-cycle pulse: transfer spi_tx_byte.
spi_tx_byte  out  8  byte to send; held stable from spi_start until spi_done.
spi_rx_byte  in  8  received byte; valid in the spi_done cycle.
spi_done  in  1  one-cycle pulse: byte transfer finished.

Behaviour:
- Reset values: cs=1, cmd_ready=1 (IDLE), spi_start=0, spi_tx_byte=8'hFF, resp_valid=0, resp_r1=8'hFF, resp_data=0, resp_timeout=0.
- One byte outstanding at most. spi_start is issued the cycle after the previous spi_done, giving a 1-cycle gap. spi_done outside a wait state is ignored.
- On accept: latch index/arg/resp_len/keep_cs, clear CRC, clear resp_timeout/resp_data.
- States:
  - IDLE: waits for accept.
  - PRE: cs=0, send 0xFF.
  - FRAME: send bytes 0..5. Byte0={2'b01,cmd_index}; bytes1-4 = arg MSB first; byte5={crc7,1'b1}. CRC updates with each of bytes 0-4 as it is issued.
  - POLL: send 0xFF and count polls. First rx with bit7==0 -> latch resp_r1. Then go to TRAIL if resp_len=1 and rx[2]==0, else POST. After NCR_MAX polls with no valid R1: resp_timeout=1, resp_r1=8'hFF, go to POST.
  - TRAIL: send 4×0xFF, shift rx into resp_data.
  - POST: if keep_cs=0, drive cs=1 and send one 0xFF (8 clocks with cs high) before DONE. If keep_cs=1, go straight to DONE with cs=0.
  - DONE: resp_valid pulse, return to IDLE.
- cs stays low from PRE through TRAIL.
- resp_r1/resp_data/resp_timeout hold until the next accept.
- Illegal-command R1 (bit2 set) with resp_len=1: trailer skipped, resp_data=0.
- CRC7: polynomial x^7+x^3+1, init 0, MSB-first, one byte per cycle.
- cmd_valid while busy is ignored, with no queuing.
- rst mid-transaction: next cycle IDLE, cs=1, no spi_start. A late spi_done is ignored. The byte engine is not aborted.

Decomposition:
- Shared package sd_pkg: state encoding; command constants (CMD0=0, CMD8=8, CMD55=55, ACMD41=41, CMD58=58); R1 bit positions (IDLE=0, ILLEGAL_CMD=2); NO_OP byte 8'hFF; start-bit pattern 2'b01.
- Sub-module sd_crc7: registered, clr/en/data[7:0] in, crc[6:0] out, one-byte-per-cycle combinational update.

Test Plan:
- CMD0, arg 0, resp_len=0, keep_cs=0; bytes-engine model returns R1=0x01 on the 2nd poll -> tx stream FF,40,00,00,00,00,95,FF,FF,FF; resp_r1=0x01, timeout=0, cs high before the final FF, one resp_valid pulse.
- CMD8, arg 0x000001AA, resp_len=1; model returns R1=0x01 then 00,00,01,AA -> byte5=0x87, resp_data=0x000001AA.
- CMD8, resp_len=1, model returns R1=0x05 -> no trailer bytes sent, resp_data=0, resp_r1=0x05.
- Model returns only 0xFF, NCR_MAX=8 -> exactly 8 poll bytes, resp_timeout=1, resp_r1=0xFF, cs released.
- CMD17 with keep_cs=1 -> no post byte, cs remains 0 after resp_valid; cmd_valid pulsed mid-frame is ignored.
- rst asserted during FRAME byte 3 -> next cycle cs=1, cmd_ready=1; pending spi_done produces no spi_start and no resp_valid.
